// File: rtl/sync_bitwise_unit.sv
// Registered op-selectable bitwise unit with valid/ready handshake,
// accumulate mode and a wrapping accepted-transaction counter.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   in_a, in_b            operands (in_b replaced by acc when in_acc=1)
//   in_op                 000 AND 001 OR 010 XOR 011 NAND
//                         100 NOR 101 XNOR 110 A&~B 111 PASS A
//   in_acc                use accumulator as second operand
//   out_valid / out_ready result handshake
//   out_data              registered result
//   out_count             accepted transactions, modulo 2^CNT_W
//   out_zero, out_ones, out_parity
//                         result flags, present only when the
//                         macro BITWISE_FLAGS_EN is defined
module sync_bitwise_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BITWISE_FLAGS_EN
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             pop;
  op_t              op;

  // A slot frees up when the held result is consumed this cycle,
  // which is what allows one result per cycle under out_ready=1.
  assign in_ready = rst_n & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  assign y  = in_acc ? acc : in_b;
  assign op = op_t'(in_op);

  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = in_a & y;
      OP_OR:   result = in_a | y;
      OP_XOR:  result = in_a ^ y;
      OP_NAND: result = ~(in_a & y);
      OP_NOR:  result = ~(in_a | y);
      OP_XNOR: result = ~(in_a ^ y);
      OP_ANDN: result = in_a & ~y;
      OP_PASS: result = in_a;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      out_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
      acc       <= result;
      out_count <= out_count + 1'b1;
    end else if (pop) begin
      // data is kept; only the valid flag drops
      out_valid <= 1'b0;
    end
  end

`ifdef BITWISE_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_zero   <= 1'b0;
      out_ones   <= 1'b0;
      out_parity <= 1'b0;
    end else if (accept) begin
      out_zero   <= (result == '0);
      out_ones   <= (result == {WIDTH{1'b1}});
      out_parity <= ^result;
    end
  end
`endif

endmodule

// File: tb/tb_sync_bitwise_unit.sv
// Directed self-checking bench for sync_bitwise_unit
// (WIDTH=4, CNT_W=4 so the counter wrap is reachable).
module tb_sync_bitwise_unit;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_op;
  logic          in_acc;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
`ifdef BITWISE_FLAGS_EN
  logic          out_zero;
  logic          out_ones;
  logic          out_parity;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] op_exp [8];

  always #5 clk = ~clk;

  sync_bitwise_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BITWISE_FLAGS_EN
    .out_zero  (out_zero),
    .out_ones  (out_ones),
    .out_parity(out_parity),
`endif
    .out_count (out_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] op,
                       input logic ac);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = ac;
  endtask

  initial begin
    op_exp[0] = 4'b1000;
    op_exp[1] = 4'b1110;
    op_exp[2] = 4'b0110;
    op_exp[3] = 4'b0111;
    op_exp[4] = 4'b0001;
    op_exp[5] = 4'b1001;
    op_exp[6] = 4'b0100;
    op_exp[7] = 4'b1100;

    // reset with input presented: dropped
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 4'hF, 4'hF, 3'b000, 1'b0);
    #1;
    chk("rst_in_ready", in_ready, 0);
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_in_ready2", in_ready, 0);

    rst_n = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 3'b000, 1'b0);
    tick();
    chk("idle_valid", out_valid, 0);
    chk("idle_count", out_count, 0);
    chk("idle_in_ready", in_ready, 1);

    // first accept, AND
    drive(1'b1, 4'b1100, 4'b1010, 3'b000, 1'b0);
    tick();
    chk("and_valid", out_valid, 1);
    chk("and_data", out_data, op_exp[0]);
    chk("and_count", out_count, 1);

    // ops 001..111 back to back
    for (int i = 1; i < 8; i++) begin
      in_op = 3'(i);
      #1;
      chk("b2b_in_ready", in_ready, 1);
      tick();
      chk($sformatf("op%0d_data", i), out_data, op_exp[i]);
      chk($sformatf("op%0d_valid", i), out_valid, 1);
    end
    chk("b2b_count", out_count, 8);

    // stall: new operands must not be taken
    out_ready = 1'b0;
    drive(1'b1, 4'hF, 4'hF, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      in_b = 4'(i);
      tick();
      chk("stall_data", out_data, 4'b1100);
      chk("stall_count", out_count, 8);
      chk("stall_valid", out_valid, 1);
    end
    in_b = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", in_ready, 1);
    tick();
    chk("popacc_data", out_data, 4'hF);
    chk("popacc_valid", out_valid, 1);
    chk("popacc_count", out_count, 9);

    // pop without accept
    drive(1'b0, 4'h0, 4'h0, 3'b000, 1'b0);
    tick();
    chk("pop_valid", out_valid, 0);
    chk("pop_data", out_data, 4'hF);
    chk("pop_count", out_count, 9);

    // accumulate chain
    drive(1'b1, 4'b1111, 4'b0011, 3'b010, 1'b0);
    tick();
    chk("chain1", out_data, 4'b1100);
    drive(1'b1, 4'b0101, 4'b0000, 3'b001, 1'b1);
    tick();
    chk("chain2", out_data, 4'b1101);
    drive(1'b1, 4'b1111, 4'b0000, 3'b000, 1'b1);
    tick();
    chk("chain3", out_data, 4'b1101);
`ifdef BITWISE_FLAGS_EN
    chk("f1101_zero", out_zero, 0);
    chk("f1101_ones", out_ones, 0);
    chk("f1101_par", out_parity, 1);
`endif
    chk("chain_count", out_count, 12);

    // zero result
    drive(1'b1, 4'b0000, 4'b1111, 3'b000, 1'b0);
    tick();
    chk("zero_data", out_data, 4'b0000);
`ifdef BITWISE_FLAGS_EN
    chk("f0000_zero", out_zero, 1);
    chk("f0000_ones", out_ones, 0);
    chk("f0000_par", out_parity, 0);
`endif
    drive(1'b1, 4'b1100, 4'b1010, 3'b001, 1'b0);
    tick();
    chk("e_data", out_data, 4'b1110);
`ifdef BITWISE_FLAGS_EN
    chk("f1110_zero", out_zero, 0);
    chk("f1110_par", out_parity, 1);
`endif
    drive(1'b1, 4'b1111, 4'b0000, 3'b111, 1'b0);
    tick();
    chk("pass_data", out_data, 4'b1111);
`ifdef BITWISE_FLAGS_EN
    chk("f1111_ones", out_ones, 1);
    chk("f1111_par", out_parity, 0);
`endif
    chk("pre_rst_count", out_count, 15);

    // reset while holding a result
    rst_n = 1'b0;
    drive(1'b1, 4'b1010, 4'b0101, 3'b001, 1'b0);
    #1;
    chk("rst2_in_ready", in_ready, 0);
    tick();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data", out_data, 0);
    chk("rst2_count", out_count, 0);
`ifdef BITWISE_FLAGS_EN
    chk("rst2_zero", out_zero, 0);
    chk("rst2_par", out_parity, 0);
`endif
    rst_n = 1'b1;

    // acc was cleared: 0000 | acc must be 0000
    drive(1'b1, 4'b0000, 4'b1111, 3'b001, 1'b1);
    tick();
    chk("post_rst_acc", out_data, 4'b0000);
    chk("post_rst_count", out_count, 1);

    // wrap: 16 more accepts -> 17 total
    drive(1'b1, 4'b0011, 4'b0101, 3'b010, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("wrap_count16", out_count, 0);
    tick();
    chk("wrap_count17", out_count, 1);
    chk("wrap_data", out_data, 4'b0110);

    drive(1'b0, 4'h0, 4'h0, 3'b000, 1'b0);
    tick();
    chk("final_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
